// File: rtl/chrono_counter_if.sv
// Control and count signals between chrono_counter and its driver.
// The master drives the controls; the slave is the counter itself.
interface chrono_counter_if;
    logic       START_STOP;
    logic       CLEAR;
    logic       LOAD;
    logic [5:0] LOAD_VAL;
    logic       UP_DN;
    logic [5:0] T;
    logic       RUN;
    logic       WRAP;

    modport master (
        output START_STOP, CLEAR, LOAD, LOAD_VAL, UP_DN,
        input  T, RUN, WRAP
    );

    modport slave (
        input  START_STOP, CLEAR, LOAD, LOAD_VAL, UP_DN,
        output T, RUN, WRAP
    );
endinterface

// File: rtl/chrono_counter.sv
// Prescaled 6-bit seconds counter with start/stop, clear, load and up/down.
// Counts wrap within 0..MAX_COUNT so the downstream display stays in range.
module chrono_counter #(
    parameter int unsigned PRESCALE  = 50,
    parameter int unsigned MAX_COUNT = 59
) (
    input logic            CLK,
    input logic            RSTN,
    chrono_counter_if.slave bus
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [5:0] MAXV = 6'(MAX_COUNT);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t        state_q, state_nx;
    logic          edge_q;
    logic [PW-1:0] pre_q, pre_nx;
    logic [5:0]    t_q, t_nx;
    logic          wrap_q, wrap_nx;
    logic          rise;
    logic          step;

    assign rise = bus.START_STOP & ~edge_q;
    assign step = (state_q == RUNNING) && (pre_q == PRE_LAST);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= STOPPED;
            edge_q  <= 1'b0;
            pre_q   <= '0;
            t_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            edge_q  <= bus.START_STOP;
            pre_q   <= pre_nx;
            t_q     <= t_nx;
            wrap_q  <= wrap_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        pre_nx   = pre_q;
        t_nx     = t_q;
        wrap_nx  = 1'b0;

        // Toggle uses the current state, so a stop edge still lets this step land
        if (rise) begin
            state_nx = (state_q == RUNNING) ? STOPPED : RUNNING;
        end

        if (state_q == RUNNING) begin
            pre_nx = step ? '0 : pre_q + PW'(1);
        end

        if (bus.CLEAR) begin
            t_nx   = '0;
            pre_nx = '0;
        end else if (bus.LOAD) begin
            t_nx   = (bus.LOAD_VAL > MAXV) ? MAXV : bus.LOAD_VAL;
            pre_nx = '0;
        end else if (step) begin
            if (bus.UP_DN) begin
                if (t_q >= MAXV) begin
                    t_nx    = '0;
                    wrap_nx = 1'b1;
                end else begin
                    t_nx = t_q + 6'd1;
                end
            end else begin
                if (t_q == 6'd0) begin
                    t_nx    = MAXV;
                    wrap_nx = 1'b1;
                end else begin
                    t_nx = t_q - 6'd1;
                end
            end
        end
    end

    assign bus.T    = t_q;
    assign bus.RUN  = (state_q == RUNNING);
    assign bus.WRAP = wrap_q;

endmodule
